instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage directly upstream of the CPU control state machine. Holds the program counter and the 16-bit instruction register. Assembles each instruction from two byte reads on the 8-bit data bus under the controller's `load_ir`/`rd` strobes, and presents `optcode[4:0]` back to the controller. Applies the controller's `inc_pc`/`load_pc` commands and drives the shared memory address.

## Interface
- `OPC_W`, default 5: opcode field width, instruction bits [15:11].
- `ADDR_W`, default 11: operand address and PC width, instruction bits [10:0]. `OPC_W + ADDR_W` must equal 16.
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: CPU enable, same signal that feeds the controller.
- `load_ir` input 1: controller strobe; capture one instruction byte this cycle.
- `rd` input 1: controller memory-read strobe; must accompany `load_ir`.
- `inc_pc` input 1: advance PC by one instruction.
- `load_pc` input 1: load PC from the instruction address field (jump).
- `data` input 8: memory read data bus.
- `mem_addr` output ADDR_W+1: memory byte address, combinational.
- `optcode` output OPC_W: `ir[15:11]`, to the controller.
- `ir_addr` output ADDR_W: `ir[10:0]`, the operand/jump address.
- `pc` output ADDR_W: current program counter, in instruction units.
- `ir_valid` output 1: a complete instruction is held in the IR.
- `halt` output 1: `ir_valid && optcode == 0`.
- `fetch_err` output 1: sticky protocol-error flag.

## Operation
- Internal state: `pc`, `ir[15:0]`, `byte_sel` (0 = high byte next, 1 = low byte next), `ir_valid`, `fetch_err`.
- Byte capture FSM, two states:
  - BYTE_HI (`byte_sel=0`): on a posedge with `ena && load_ir && rd`, `ir[15:8] <= data`, `ir_valid <= 0`, go to BYTE_LO.
  - BYTE_LO (`byte_sel=1`): on a posedge with `ena && load_ir && rd`, `ir[7:0] <= data`, `ir_valid <= 1`, go to BYTE_HI.
  - A cycle without `load_ir` leaves the state unchanged.
- Protocol error: `load_ir` high with `rd` low and `ena` high:
  - no capture and no `byte_sel` change;
  - `fetch_err <= 1`, which stays set until reset.
- PC update:
  - `load_pc`: `pc <= ir[10:0]`.
  - else `inc_pc`: `pc <= pc + 1`, modulo 2^ADDR_W, so 0x7FF wraps to 0x000.
  - `load_pc` and `inc_pc` together: `load_pc` wins.
- Address mux:
  - `mem_addr = load_ir ? {pc, byte_sel} : {1'b0, ir[10:0]}`.
  - The instruction fetch occupies byte pairs 2·pc and 2·pc+1; operands live in the lower half of the byte space.
- `ena` low, synchronous: `byte_sel <= 0`. PC, IR, `ir_valid` and `fetch_err` hold, and all strobes are ignored. This realigns with the controller, which returns to its fetch state when `ena` drops.

## Timing
- The controller updates its strobes on negedge; this block samples them on the following posedge.
- Controller fetch sequence:
  - state 0 (`load_ir`, `rd`) → high byte captured at posedge N.
  - state 1 (`load_ir`, `rd`, `inc_pc`) → low byte captured at posedge N+1, and `pc` increments on the same edge.
- Output latency:
  - `optcode`, `ir_addr` and `ir_valid` are valid from posedge N+1.
  - The controller first decodes `optcode` at its state 3 negedge, which is well after N+1.
- `mem_addr` is combinational. During the state 1 fetch it shows the pre-increment PC with `byte_sel=1`.
- Jump: `load_pc` is sampled in the posedge after the controller's state 3 negedge. The new PC is visible on the next cycle, and state 4's redundant `load_pc` reloads the same value.
- Reset values while `rst_n` is low, asynchronously: `pc=0`, `ir=0`, `byte_sel=0`, `ir_valid=0`, `fetch_err=0`. Derived outputs follow: `optcode=0`, `ir_addr=0`, `halt=0`, and `mem_addr=0` (with `load_ir` low, `mem_addr = {1'b0, ir[10:0]} = 0`).
- Reset asserted mid-fetch, between the high and low byte, discards the partial instruction.

## Test plan
- Reset, then fetch bytes 0x2A, 0x05 with `inc_pc` on the second byte → `optcode=5'b00101` (lda), `ir_addr=0x205`, `ir_valid=1`, `pc=1`. `mem_addr` reads 0x000 then 0x001 during the fetch.
- IR = 0x3812 (jmp, address 0x012), pulse `load_pc` together with `inc_pc` → `pc=0x012`; the increment is ignored.
- `pc` at 0x7FF, `inc_pc` → `pc=0x000`. Then fetch 0x00, 0x00 → `halt=1`.
- High byte 0xAB captured, then `ena` low for one cycle, then fetch 0x10, 0x20 → `ir=0x1020`, with 0x10 landing in the high byte.
- `load_ir=1`, `rd=0` → `fetch_err=1`, IR and `byte_sel` unchanged. `fetch_err` stays set through later normal fetches and clears only on `rst_n` low.
- Assert `rst_n` low asynchronously between posedges in the middle of a fetch → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, 16-bit instruction register built from two
// byte reads, and the memory address mux shared between instruction fetch and operand access.
module instr_fetch_unit #(
    parameter int OPC_W  = 5,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load_ir,
    input  logic              rd,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic [7:0]        data,
    output logic [ADDR_W:0]   mem_addr,
    output logic [OPC_W-1:0]  optcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_valid,
    output logic              halt,
    output logic              fetch_err
);
    localparam int IR_W = OPC_W + ADDR_W;

    typedef enum logic {BYTE_HI = 1'b0, BYTE_LO = 1'b1} byte_state_t;

    byte_state_t       state, state_nx;
    logic [IR_W-1:0]   ir;
    logic              cap_hi, cap_lo, err_set, byte_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BYTE_HI;
        else        state <= state_nx;
    end

    // Dropping ena realigns to the high byte, matching the controller's return to fetch.
    always_comb begin
        state_nx = state;
        cap_hi   = 1'b0;
        cap_lo   = 1'b0;
        err_set  = 1'b0;
        if (!ena) begin
            state_nx = BYTE_HI;
        end else if (load_ir) begin
            if (rd) begin
                case (state)
                    BYTE_HI: begin cap_hi = 1'b1; state_nx = BYTE_LO; end
                    BYTE_LO: begin cap_lo = 1'b1; state_nx = BYTE_HI; end
                    default: state_nx = BYTE_HI;
                endcase
            end else begin
                err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= '0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            if (cap_hi) begin
                ir[IR_W-1 -: 8] <= data;
                ir_valid        <= 1'b0;
            end
            if (cap_lo) begin
                ir[7:0]  <= data;
                ir_valid <= 1'b1;
            end
            if (err_set) fetch_err <= 1'b1;
        end
    end

    // Jump wins over increment; increment wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (ena) begin
            if (load_pc)     pc <= ir[ADDR_W-1:0];
            else if (inc_pc) pc <= pc + ADDR_W'(1);
        end
    end

    assign byte_sel = (state == BYTE_LO);
    assign mem_addr = load_ir ? {pc, byte_sel} : {1'b0, ir[ADDR_W-1:0]};
    assign optcode  = ir[IR_W-1 -: OPC_W];
    assign ir_addr  = ir[ADDR_W-1:0];
    assign halt     = ir_valid && (optcode == '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected state snapshots and
// completed instructions; a monitor pops and compares them as the DUT presents outputs.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0, load_ir = 1'b0, rd = 1'b0, inc_pc = 1'b0, load_pc = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [11:0] mem_addr;
    logic [4:0]  optcode;
    logic [10:0] ir_addr, pc;
    logic        ir_valid, halt, fetch_err;

    int checks = 0;
    int failures = 0;

    instr_fetch_unit #(.OPC_W(5), .ADDR_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load_ir(load_ir), .rd(rd),
        .inc_pc(inc_pc), .load_pc(load_pc), .data(data), .mem_addr(mem_addr),
        .optcode(optcode), .ir_addr(ir_addr), .pc(pc), .ir_valid(ir_valid),
        .halt(halt), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [10:0] pc;
        logic [11:0] ma;
        logic [15:0] ir;
        logic        vld, err, hlt;
    } snap_t;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic        hlt;
    } inst_t;

    snap_t snap_q[$];
    inst_t inst_q[$];

    task automatic check(input string name, input string field,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=0x%0h expected=0x%0h", name, field, act, exp);
        end
    endtask

    // Inputs change on negedge, as the controller does.
    task automatic drive(input logic e, input logic li, input logic r,
                         input logic ip, input logic lp, input logic [7:0] d);
        @(negedge clk);
        ena = e; load_ir = li; rd = r; inc_pc = ip; load_pc = lp; data = d;
    endtask

    // Expected state for the cycle just driven (state from the last posedge, current inputs).
    task automatic snap(input string name, input logic [10:0] p, input logic [11:0] ma,
                        input logic [15:0] ir, input logic vld, input logic err, input logic hlt);
        snap_t s;
        s.name = name; s.pc = p; s.ma = ma; s.ir = ir; s.vld = vld; s.err = err; s.hlt = hlt;
        snap_q.push_back(s);
    endtask

    task automatic expect_inst(input string name, input logic [15:0] ir, input logic hlt);
        inst_t i;
        i.name = name; i.ir = ir; i.hlt = hlt;
        inst_q.push_back(i);
    endtask

    task automatic fetch(input logic [7:0] hi, input logic [7:0] lo, input logic inc);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, hi);
        drive(1'b1, 1'b1, 1'b1, inc, 1'b0, lo);
    endtask

    // Monitor: samples mid-cycle, after the negedge drive has settled.
    logic prev_vld = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            check(s.name, "pc",        16'(pc),                 16'(s.pc));
            check(s.name, "mem_addr",  16'(mem_addr),           16'(s.ma));
            check(s.name, "ir",        {optcode, ir_addr},      s.ir);
            check(s.name, "ir_valid",  16'(ir_valid),           16'(s.vld));
            check(s.name, "fetch_err", 16'(fetch_err),          16'(s.err));
            check(s.name, "halt",      16'(halt),               16'(s.hlt));
        end
        if (ir_valid && !prev_vld) begin
            if (inst_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_inst got ir=0x%0h expected=no instruction",
                         {optcode, ir_addr});
            end else begin
                inst_t i;
                i = inst_q.pop_front();
                check(i.name, "inst_ir",   {optcode, ir_addr}, i.ir);
                check(i.name, "inst_halt", 16'(halt),          16'(i.hlt));
            end
        end
        prev_vld = ir_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("reset", 11'h000, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // lda fetch: mem_addr 0x000 then 0x001
        expect_inst("lda", 16'h2A05, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2A);
        snap("lda_hi", 11'h000, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h05);
        snap("lda_lo", 11'h000, 12'h001, 16'h2A00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("lda_done", 11'h001, 12'h205, 16'h2A05, 1'b1, 1'b0, 1'b0);

        // jmp: load_pc beats inc_pc
        expect_inst("jmp", 16'h3812, 1'b0);
        fetch(8'h38, 8'h12, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        snap("jmp_pre", 11'h002, 12'h012, 16'h3812, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("jmp_done", 11'h012, 12'h012, 16'h3812, 1'b1, 1'b0, 1'b0);

        // PC wrap at 0x7FF, then halt instruction
        expect_inst("ld7ff", 16'h07FF, 1'b1);
        fetch(8'h07, 8'hFF, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        snap("pc_7ff", 11'h7FF, 12'h7FF, 16'h07FF, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("pc_wrap", 11'h000, 12'h7FF, 16'h07FF, 1'b1, 1'b0, 1'b1);
        expect_inst("hlt", 16'h0000, 1'b1);
        fetch(8'h00, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("hlt_done", 11'h001, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b1);

        // ena drop after a high byte realigns and ignores strobes
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAB);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        snap("ena_low", 11'h001, 12'h003, 16'hAB00, 1'b0, 1'b0, 1'b0);
        expect_inst("realign", 16'h1020, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        snap("realign_hi", 11'h001, 12'h002, 16'hAB00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("realign_done", 11'h002, 12'h020, 16'h1020, 1'b1, 1'b0, 1'b0);

        // Protocol error: no capture, sticky flag
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        snap("err_pre", 11'h002, 12'h004, 16'h1020, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("err_set", 11'h002, 12'h020, 16'h1020, 1'b1, 1'b1, 1'b0);
        expect_inst("after_err", 16'hC801, 1'b0);
        fetch(8'hC8, 8'h01, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("err_sticky", 11'h003, 12'h001, 16'hC801, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset between posedges, mid-fetch
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("async_rst", 11'h000, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_inst("post_rst", 16'h1234, 1'b0);
        fetch(8'h12, 8'h34, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        snap("post_rst_done", 11'h001, 12'h234, 16'h1234, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #4;
        while (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s got=not sampled expected=sampled", s.name);
        end
        while (inst_q.size() > 0) begin
            inst_t i;
            i = inst_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s got=no instruction expected=ir 0x%0h", i.name, i.ir);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
